// File: rtl/pkt_dispatch.sv
// Packet classifier and dispatcher: maps packet type to consumer channels, buffers packets in a
// small FIFO and presents each one to its channels until every channel has acknowledged it.
module pkt_dispatch #(
  parameter int unsigned ID_W   = 16,
  parameter int unsigned TYPE_W = 3,
  parameter int unsigned NUM_CH = 4,
  parameter logic [NUM_CH*(2**TYPE_W)-1:0] CH_MAP = 32'h0112_1862,
  parameter int unsigned DEPTH  = 4,
  parameter bit          FILTER_FOREIGN = 1'b0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              newpkt,
  input  logic [TYPE_W-1:0] fPktType,
  input  logic [ID_W-1:0]   myNodeID,
  input  logic [ID_W-1:0]   destinationID,
  output logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_ack,
  output logic [TYPE_W-1:0] pktType_o,
  output logic              iAmDestination,
  output logic              isBroadcast,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned OCC_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = TYPE_W + 2 + NUM_CH;

  typedef enum logic [0:0] {StEmpty, StPresent} state_e;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]   count_q;

  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [TYPE_W-1:0]  type_q, type_d;
  logic               match_q, match_d;
  logic               bcast_q, bcast_d;
  logic               overflow_q;
  logic [CNT_W-1:0]   drop_cnt_q;

  logic               in_match, in_bcast, accept, full, pop, push, drop;
  logic [NUM_CH-1:0]  in_mask;
  logic [ENTRY_W-1:0] head_entry;

  always_comb begin
    in_match = (destinationID == myNodeID);
    in_bcast = &destinationID;
    in_mask  = CH_MAP[fPktType*NUM_CH +: NUM_CH];
    accept   = newpkt && (|in_mask) && (!FILTER_FOREIGN || in_match || in_bcast);
    full     = (count_q == OCC_W'(DEPTH));
    pop      = (state_q == StEmpty) && (count_q != '0);
    // A full FIFO still takes a packet when the head drains an entry in the same cycle.
    push     = accept && (!full || pop);
    drop     = accept && full && !pop;
  end

  assign head_entry = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {fPktType, in_match, in_bcast, in_mask};
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    type_d    = type_q;
    match_d   = match_q;
    bcast_d   = bcast_q;
    unique case (state_q)
      StEmpty: begin
        if (pop) begin
          {type_d, match_d, bcast_d, pending_d} = head_entry;
          state_d = StPresent;
        end
      end
      StPresent: begin
        pending_d = pending_q & ~ch_ack;
        if (pending_d == '0) begin
          // Head fields read as zero while nothing is presented.
          state_d = StEmpty;
          type_d  = '0;
          match_d = 1'b0;
          bcast_d = 1'b0;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= StEmpty;
      pending_q  <= '0;
      type_q     <= '0;
      match_q    <= 1'b0;
      bcast_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      type_q     <= type_d;
      match_q    <= match_d;
      bcast_q    <= bcast_d;
      overflow_q <= drop;
      if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign ch_en          = pending_q;
  assign pktType_o      = type_q;
  assign iAmDestination = match_q;
  assign isBroadcast    = bcast_q;
  assign busy           = (state_q == StPresent) || (count_q != '0);
  assign overflow       = overflow_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_pkt_dispatch.sv
// Scoreboard bench for pkt_dispatch: one instance without and one with foreign-packet filtering,
// both driven by the same stimulus and each checked against its own expected-packet queue.
module tb_pkt_dispatch;

  logic        clk = 1'b0;
  logic        nrst, newpkt;
  logic [2:0]  ptype;
  logic [15:0] my_id, dest;
  logic [3:0]  ack;

  logic [3:0]  en_a, en_b;
  logic [2:0]  type_a, type_b;
  logic        iam_a, iam_b, bc_a, bc_b, busy_a, busy_b, ovf_a, ovf_b;
  logic [7:0]  cnt_a, cnt_b;

  int n_checks = 0;
  int n_pass   = 0;
  int ovf_a_n  = 0;
  int ovf_b_n  = 0;
  logic [3:0] prev_a, prev_b;
  logic [8:0] q_a [$];
  logic [8:0] q_b [$];

  always #5 clk = ~clk;

  pkt_dispatch u_dut_a (
    .clk(clk), .nrst(nrst), .newpkt(newpkt), .fPktType(ptype), .myNodeID(my_id),
    .destinationID(dest), .ch_en(en_a), .ch_ack(ack), .pktType_o(type_a),
    .iAmDestination(iam_a), .isBroadcast(bc_a), .busy(busy_a), .overflow(ovf_a),
    .drop_cnt(cnt_a)
  );

  pkt_dispatch #(.FILTER_FOREIGN(1'b1)) u_dut_b (
    .clk(clk), .nrst(nrst), .newpkt(newpkt), .fPktType(ptype), .myNodeID(my_id),
    .destinationID(dest), .ch_en(en_b), .ch_ack(ack), .pktType_o(type_b),
    .iAmDestination(iam_b), .isBroadcast(bc_b), .busy(busy_b), .overflow(ovf_b),
    .drop_cnt(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Channel mask per type, written from the routing table rather than the packed map.
  function automatic logic [3:0] exp_mask(input logic [2:0] t);
    case (t)
      3'd0, 3'd4:       return 4'b0010;
      3'd1:             return 4'b0110;
      3'd2:             return 4'b1000;
      3'd3, 3'd5, 3'd6: return 4'b0001;
      default:          return 4'b0000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] t, input logic [15:0] d, input bit drop);
    logic [3:0] m;
    logic       mt, bc;
    m  = exp_mask(t);
    mt = (d == my_id);
    bc = &d;
    if (m != 4'b0 && !drop) begin
      q_a.push_back({t, mt, bc, m});
      if (mt || bc) q_b.push_back({t, mt, bc, m});
    end
    newpkt = 1'b1;
    ptype  = t;
    dest   = d;
    step();
    newpkt = 1'b0;
  endtask

  task automatic wait_present();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (en_a != 4'b0) return;
      step();
    end
    check_eq("wait_present_timeout", {31'b0, en_a != 4'b0}, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_en_a"},   en_a,   0);
    check_eq({tag, "_en_b"},   en_b,   0);
    check_eq({tag, "_type_a"}, type_a, 0);
    check_eq({tag, "_iam_a"},  iam_a,  0);
    check_eq({tag, "_bc_a"},   bc_a,   0);
    check_eq({tag, "_busy_a"}, busy_a, 0);
    check_eq({tag, "_busy_b"}, busy_b, 0);
    check_eq({tag, "_ovf_a"},  ovf_a,  0);
    check_eq({tag, "_cnt_a"},  cnt_a,  0);
    check_eq({tag, "_cnt_b"},  cnt_b,  0);
  endtask

  // New presentation = ch_en rising from zero (there is always an idle cycle between packets).
  always @(negedge clk) begin
    if (!nrst) begin
      prev_a <= 4'b0;
      prev_b <= 4'b0;
    end else begin
      if (en_a != 4'b0 && prev_a == 4'b0) begin
        if (q_a.size() == 0) check_eq("unexpected_a", {type_a, iam_a, bc_a, en_a}, 0);
        else check_eq("present_a", {type_a, iam_a, bc_a, en_a}, q_a.pop_front());
      end
      if (en_b != 4'b0 && prev_b == 4'b0) begin
        if (q_b.size() == 0) check_eq("unexpected_b", {type_b, iam_b, bc_b, en_b}, 0);
        else check_eq("present_b", {type_b, iam_b, bc_b, en_b}, q_b.pop_front());
      end
      if (ovf_a) ovf_a_n <= ovf_a_n + 1;
      if (ovf_b) ovf_b_n <= ovf_b_n + 1;
      prev_a <= en_a;
      prev_b <= en_b;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b0; newpkt = 1'b0; ptype = '0; my_id = 16'h0005; dest = '0; ack = '0;
    repeat (2) step();
    nrst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check_idle("reset");

    // Type 1 for this node, ack held high on every channel.
    ack = 4'hF;
    send(3'd1, 16'h0005, 1'b0);
    @(negedge clk); check_eq("t1_en_early", en_a, 4'b0000);
    step(); @(negedge clk);
    check_eq("t1_en_a", en_a, 4'b0110);
    check_eq("t1_en_b", en_b, 4'b0110);
    check_eq("t1_iam", iam_a, 1);
    step(); @(negedge clk); check_eq("t1_en_off", en_a, 4'b0000);
    step(); @(negedge clk);
    check_eq("t1_busy_a", busy_a, 0);
    check_eq("t1_busy_b", busy_b, 0);

    // Foreign type 3: presented only without filtering.
    send(3'd3, 16'h0009, 1'b0);
    step(); @(negedge clk);
    check_eq("foreign_en_a", en_a, 4'b0001);
    check_eq("foreign_iam_a", iam_a, 0);
    check_eq("foreign_en_b", en_b, 4'b0000);
    repeat (2) step();
    send(3'd3, 16'hFFFF, 1'b0);
    step(); @(negedge clk);
    check_eq("bcast_en_b", en_b, 4'b0001);
    check_eq("bcast_bc_b", bc_b, 1);
    repeat (3) step();

    // Staggered acks on a type-1 packet.
    ack = 4'b0;
    send(3'd1, 16'h0005, 1'b0);
    step(); @(negedge clk); check_eq("stag_t2", en_a, 4'b0110);
    step(); ack = 4'b0010; @(negedge clk); check_eq("stag_t3", en_a, 4'b0110);
    step(); ack = 4'b0000; @(negedge clk); check_eq("stag_t4", en_a, 4'b0100);
    step();
    step(); ack = 4'b0100; @(negedge clk); check_eq("stag_t6", en_a, 4'b0100);
    step(); ack = 4'b0000; @(negedge clk); check_eq("stag_t7", en_a, 4'b0000);
    send(3'd7, 16'h0005, 1'b0);
    repeat (3) step();
    @(negedge clk);
    check_eq("t7_en", en_a, 4'b0000);
    check_eq("t7_busy", busy_a, 0);
    check_eq("t7_ovf_seen", ovf_a_n, 0);

    // Burst of six with no acks: head + four buffered, sixth dropped.
    send(3'd0, 16'h0005, 1'b0);
    send(3'd0, 16'hFFFF, 1'b0);
    send(3'd0, 16'h0005, 1'b0);
    send(3'd0, 16'hFFFF, 1'b0);
    send(3'd0, 16'h0005, 1'b0);
    send(3'd0, 16'hFFFF, 1'b1);
    @(negedge clk);
    check_eq("burst_ovf_a", ovf_a, 1);
    check_eq("burst_cnt_a", cnt_a, 1);
    check_eq("burst_ovf_b", ovf_b, 1);
    check_eq("burst_cnt_b", cnt_b, 1);
    step(); @(negedge clk);
    check_eq("burst_ovf_pulse", ovf_a, 0);
    check_eq("burst_cnt_hold", cnt_a, 1);
    for (int i = 0; i < 5; i++) begin
      wait_present();
      ack = 4'b0010;
      step();
      ack = 4'b0000;
    end
    repeat (2) step();
    @(negedge clk);
    check_eq("burst_q_a", q_a.size(), 0);
    check_eq("burst_q_b", q_b.size(), 0);
    check_eq("burst_busy", busy_a, 0);
    check_eq("burst_ovf_cnt_a", ovf_a_n, 1);
    check_eq("burst_ovf_cnt_b", ovf_b_n, 1);

    // Reset while presenting with packets still buffered.
    send(3'd0, 16'h0005, 1'b0);
    send(3'd0, 16'h0005, 1'b0);
    send(3'd0, 16'h0005, 1'b0);
    @(negedge clk);
    check_eq("prereset_en", en_a, 4'b0010);
    check_eq("prereset_busy", busy_a, 1);
    nrst = 1'b0;
    step(); @(negedge clk);
    check_idle("midreset");
    q_a.delete();
    q_b.delete();
    nrst = 1'b1;
    repeat (6) step();
    @(negedge clk);
    check_eq("postreset_en", en_a, 4'b0000);
    check_eq("postreset_busy", busy_a, 0);
    ack = 4'hF;
    send(3'd2, 16'h0005, 1'b0);
    wait_present();
    check_eq("postreset_pkt", en_a, 4'b1000);
    repeat (3) step();
    @(negedge clk);
    check_eq("final_q_a", q_a.size(), 0);
    check_eq("final_q_b", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pkt_dispatch.md
# pkt_dispatch

Parametrised packet classifier and dispatcher for the node receive path, between the packet parser and the consumer blocks (Q-table update, member/neighbour info, cluster-head election and invitation handling). Each new packet is classified by type through a configurable type-to-channel map, tagged with a destination match, and buffered in a small FIFO. Each packet is then presented to every mapped consumer channel with a level enable, which stays high until that channel acknowledges. Consumers that take more than one cycle no longer lose packets, and a burst of packets is absorbed instead of being overwritten.

## Interface
Parameters:
- ID_W, 16, width of node IDs.
- TYPE_W, 3, width of the packet-type field.
- NUM_CH, 4, number of consumer channels. Default channels: 0 = QTU, 1 = MNI, 2 = KCH_CHE, 3 = KCH_INV.
- CH_MAP, 32'h0112_1862, NUM_CH*2^TYPE_W bits. Bits [t*NUM_CH +: NUM_CH] give the channel mask for type t. The default map routes:
  - types 3, 5, 6 to QTU;
  - types 0, 1, 4 to MNI;
  - type 1 to KCH_CHE;
  - type 2 to KCH_INV;
  - type 7 to nothing.
- DEPTH, 4, FIFO entries. Power of two, ≥2.
- FILTER_FOREIGN, 0. When 1, packets that are neither for this node nor broadcast are discarded.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- newpkt  in  1  one-cycle strobe; the other packet inputs are valid in the same cycle.
- fPktType  in  TYPE_W  packet type.
- myNodeID  in  ID_W  this node's ID.
- destinationID  in  ID_W  packet destination ID.
- ch_en  out  NUM_CH  per-channel enable (level).
- ch_ack  in  NUM_CH  per-channel acknowledge.
- pktType_o  out  TYPE_W  type of the packet being presented.
- iAmDestination  out  1  presented packet has destinationID == myNodeID.
- isBroadcast  out  1  presented packet has destinationID == all ones.
- busy  out  1  head occupied or FIFO non-empty.
- overflow  out  1  one-cycle pulse when a packet is dropped because the FIFO is full.
- drop_cnt  out  CNT_W  saturating count of FIFO-full drops.

## Operation
- Ingress, in the newpkt cycle:
  - match = (destinationID == myNodeID);
  - bcast = (destinationID == {ID_W{1'b1}});
  - mask = CH_MAP slice for fPktType.
- Discard rules, silent (no overflow pulse, no count):
  - mask == 0;
  - FILTER_FOREIGN = 1 and !match and !bcast.
- Accepted packets push {type, match, bcast, mask} into the FIFO.
- FIFO full check: a push into a full FIFO is accepted only if a pop occurs in the same cycle. Otherwise the packet is dropped, overflow pulses, and drop_cnt increments, saturating at 2^CNT_W−1 without wrapping.
- Head register, two states:
  - EMPTY: if the FIFO is non-empty, pop into the head, set pending = mask, go to PRESENT.
  - PRESENT: ch_en = pending. A bit clears when ch_ack[i] and pending[i] are both high.
    - When pending becomes all-zero, go to EMPTY.
    - The next packet loads on the following edge, so there is one idle cycle between packets.
- Head outputs: pktType_o, iAmDestination and isBroadcast are stable for the whole PRESENT period and 0 in EMPTY.
- ch_ack rules:
  - ack on a channel that is not pending is ignored;
  - simultaneous acks on several channels all clear in the same cycle;
  - ack may be held high.
- Reset (nrst low at an edge), including mid-dispatch:
  - FIFO emptied, head set to EMPTY;
  - ch_en, pktType_o, iAmDestination, isBroadcast, busy, overflow = 0;
  - drop_cnt = 0.

## Timing
- All outputs are registered.
- Empty pipeline: newpkt high in cycle t gives a FIFO write at the end of t, the head load at the end of t+1, and ch_en high in cycle t+2.
- ch_ack high in cycle k on the last pending channel gives ch_en = 0 in k+1. The next packet's ch_en is high in k+2.
- overflow is high in cycle t+1 for a drop in cycle t. drop_cnt updates in the same cycle t+1.
- Sustained throughput: one packet per two cycles when every channel acks in its first enabled cycle.

## Test plan
- Reset, then idle: all outputs 0, busy = 0.
- Type 1, myNodeID = destinationID = 16'h0005, ack held high on all channels: ch_en = 4'b0110 in t+2 only, iAmDestination = 1, then busy = 0 by t+4.
- Type 3, destinationID = 16'h0009, myNodeID = 16'h0005: with FILTER_FOREIGN = 0, ch_en = 4'b0001 and iAmDestination = 0; with FILTER_FOREIGN = 1, nothing is presented. Repeat with destinationID = 16'hFFFF and FILTER_FOREIGN = 1: presented with isBroadcast = 1.
- Type 1, ack ch1 at t+3, ack ch2 at t+6: ch_en goes 0110 → 0100 at t+4, then 0000 at t+7. Type 7 packet: never presented, no overflow.
- Six back-to-back type-0 packets, no acks, DEPTH = 4:
  - one in the head, four in the FIFO, sixth dropped;
  - overflow pulses once, drop_cnt = 1;
  - then ack each in turn: five packets are presented in order.
- Assert nrst mid-PRESENT with the FIFO non-empty: next cycle all outputs 0. The FIFO is empty afterwards, so no stale packet appears after reset is released.
